sr_async_reset: RTL and testbench

//  Serial-in/serial-out shift register: a chain of DEPTH D flip-flops clocked by clk.
//  It delays a 1-bit serial stream by exactly DEPTH clock cycles.

---
 rtl/sr_async_reset_pkg.sv | 17 +
 rtl/sr_async_reset_stage.sv | 30 +++
 rtl/sr_async_reset.sv | 62 ++++++
 tb/tb_sr_async_reset.sv | 204 ++++++++++++++++++++
 4 files changed

// File: rtl/sr_async_reset_pkg.sv
// ---------------------------------------------------------------------------
// sr_async_reset_pkg
//   Shared constants and helpers for the serial delay line.
//   SR_MIN_DEPTH : smallest legal number of flop stages.
//   sr_depth_ok  : elaboration-time legality test for a requested depth.
// ---------------------------------------------------------------------------
package sr_async_reset_pkg;

  // A delay line needs at least one flop to exist at all.
  localparam int SR_MIN_DEPTH = 1;

  // Returns 1 when the requested depth can be built.
  function automatic bit sr_depth_ok(input int depth);
    return depth >= SR_MIN_DEPTH;
  endfunction

endpackage

// File: rtl/sr_async_reset_stage.sv
// ---------------------------------------------------------------------------
// sr_async_reset_stage
//   One storage element of the serial delay line: a D flop that loads
//   RESET_VAL on any rising edge where reset is high.
// Ports
//   clk   in  1  rising-edge clock
//   reset in  1  synchronous, active-high reset
//   d     in  1  next-state data
//   q     out 1  registered data
// ---------------------------------------------------------------------------
module sr_async_reset_stage #(
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic d,
  output logic q
);

  // Reset is only looked at on the clock edge, so a reset pulse that
  // starts and ends between edges leaves the stored bit untouched.
  always_ff @(posedge clk) begin
    if (reset) begin
      q <= RESET_VAL;
    end else begin
      q <= d;
    end
  end

endmodule

// File: rtl/sr_async_reset.sv
// ---------------------------------------------------------------------------
// sr_async_reset
//   Serial-in/serial-out shift register giving a fixed delay of DEPTH
//   clock cycles on a 1-bit stream.
// Parameters
//   DEPTH     number of flop stages (= latency in cycles), >= 1
//   RESET_VAL value loaded into every stage by reset
// Ports
//   clk   in  1  single clock, rising-edge
//   reset in  1  synchronous, active-high reset
//   s_in  in  1  serial data input
//   s_out out 1  serial data output, driven straight from the last stage
// ---------------------------------------------------------------------------
module sr_async_reset
  import sr_async_reset_pkg::*;
#(
  parameter int   DEPTH     = 4,
  parameter logic RESET_VAL = 1'b0
) (
  input  logic clk,
  input  logic reset,
  input  logic s_in,
  output logic s_out
);

  // Refuse to elaborate a chain with no stages.
  if (!sr_depth_ok(DEPTH)) begin : g_depth_check
    $error("sr_async_reset: DEPTH must be >= 1");
  end

  // stage[0] sits next to s_in, stage[DEPTH-1] drives s_out.
  logic [DEPTH-1:0] stage;

  // Build the chain: the first stage samples the serial input, every
  // later stage samples its predecessor.
  for (genvar i = 0; i < DEPTH; i++) begin : g_stage
    if (i == 0) begin : g_first
      sr_async_reset_stage #(
        .RESET_VAL(RESET_VAL)
      ) u_stage (
        .clk  (clk),
        .reset(reset),
        .d    (s_in),
        .q    (stage[0])
      );
    end else begin : g_next
      sr_async_reset_stage #(
        .RESET_VAL(RESET_VAL)
      ) u_stage (
        .clk  (clk),
        .reset(reset),
        .d    (stage[i-1]),
        .q    (stage[i])
      );
    end
  end

  // Output comes directly from a flop, so there is no combinational
  // path from s_in to s_out.
  assign s_out = stage[DEPTH-1];

endmodule

// File: tb/tb_sr_async_reset.sv
// ---------------------------------------------------------------------------
// tb_sr_async_reset
//   Self-checking bench for the serial delay line. Three instances share
//   the stimulus: DEPTH=4/RESET_VAL=0, DEPTH=1/RESET_VAL=1 and
//   DEPTH=8/RESET_VAL=1.
// ---------------------------------------------------------------------------
module tb_sr_async_reset;

  logic clk;
  logic reset;
  logic s_in;
  logic out4;
  logic out1;
  logic out8;

  int vec_count;
  int miss_count;

  // Per-edge record of what the designs sampled.
  bit hist_in[$];
  bit hist_rst[$];

  typedef struct {
    bit reset;
    bit s_in;
    bit exp4;
  } vec_t;

  vec_t vecs[$];

  sr_async_reset #(.DEPTH(4), .RESET_VAL(1'b0)) dut4 (
    .clk  (clk),
    .reset(reset),
    .s_in (s_in),
    .s_out(out4)
  );

  sr_async_reset #(.DEPTH(1), .RESET_VAL(1'b1)) dut1 (
    .clk  (clk),
    .reset(reset),
    .s_in (s_in),
    .s_out(out1)
  );

  sr_async_reset #(.DEPTH(8), .RESET_VAL(1'b1)) dut8 (
    .clk  (clk),
    .reset(reset),
    .s_in (s_in),
    .s_out(out8)
  );

  // Free-running clock, period 10.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: the output after edge n is the bit sampled on edge
  // n-depth+1, unless any edge in that window had reset high.
  function automatic logic model_out(input int depth, input bit rv);
    int n;
    n = hist_in.size() - 1;
    for (int j = 0; j < depth; j++) begin
      if (n - j < 0) return 1'bx;
      if (hist_rst[n - j]) return rv;
    end
    return hist_in[n - depth + 1];
  endfunction

  // Drive inputs on the falling edge, let one rising edge sample them,
  // log what was sampled, then step off the edge for checking.
  task automatic applyStimulus(input bit r, input bit s);
    @(negedge clk);
    reset = r;
    s_in  = s;
    @(posedge clk);
    hist_rst.push_back(r);
    hist_in.push_back(s);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic act, input logic exp);
    vec_count++;
    if (act !== exp) begin
      miss_count++;
      $display("[TB] FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  task automatic checkAllModel(input string tag);
    checkOutput({tag, "/d1"}, out1, model_out(1, 1'b1));
    checkOutput({tag, "/d4"}, out4, model_out(4, 1'b0));
    checkOutput({tag, "/d8"}, out8, model_out(8, 1'b1));
  endtask

  function automatic void add_vec(input bit r, input bit s, input bit e);
    vec_t v;
    v.reset = r;
    v.s_in  = s;
    v.exp4  = e;
    vecs.push_back(v);
  endfunction

  initial begin
    logic held;
    vec_count  = 0;
    miss_count = 0;
    reset      = 1'b0;
    s_in       = 1'b0;

    // Reset held two edges with s_in=1: output stays at reset value.
    add_vec(1, 1, 0);
    add_vec(1, 1, 0);
    // Single 1 appears after the fourth edge only.
    add_vec(0, 1, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 1);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);
    // Alternating 0,1,... for 11 cycles, seen 4 cycles later.
    add_vec(0, 0, 0);
    add_vec(0, 1, 0);
    add_vec(0, 0, 0);
    add_vec(0, 1, 0);
    add_vec(0, 0, 1);
    add_vec(0, 1, 0);
    add_vec(0, 0, 1);
    add_vec(0, 1, 0);
    add_vec(0, 0, 1);
    add_vec(0, 1, 0);
    add_vec(0, 0, 1);
    // Pattern 1,1,0,1,1,0,1,1,0 followed by three flush zeros.
    add_vec(0, 1, 0);
    add_vec(0, 1, 1);
    add_vec(0, 0, 0);
    add_vec(0, 1, 1);
    add_vec(0, 1, 1);
    add_vec(0, 0, 0);
    add_vec(0, 1, 1);
    add_vec(0, 1, 1);
    add_vec(0, 0, 0);
    add_vec(0, 0, 1);
    add_vec(0, 0, 1);
    add_vec(0, 0, 0);
    // Load 1111, reset one edge, then zeros: no stale 1 may emerge.
    add_vec(0, 1, 0);
    add_vec(0, 1, 0);
    add_vec(0, 1, 0);
    add_vec(0, 1, 1);
    add_vec(1, 1, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);
    add_vec(0, 0, 0);

    $display("[TB] table phase: %0d vectors", vecs.size());
    foreach (vecs[k]) begin
      applyStimulus(vecs[k].reset, vecs[k].s_in);
      checkOutput($sformatf("table%0d/d4", k), out4, vecs[k].exp4);
      checkOutput($sformatf("table%0d/d1", k), out1, model_out(1, 1'b1));
      checkOutput($sformatf("table%0d/d8", k), out8, model_out(8, 1'b1));
    end

    // Reset pulse entirely between edges must be ignored.
    $display("[TB] between-edge reset pulse");
    applyStimulus(0, 1);
    applyStimulus(0, 1);
    held = out4;
    #1 reset = 1'b1;
    #2 reset = 1'b0;
    checkOutput("glitch_hold/d4", out4, held);
    applyStimulus(0, 0);
    checkOutput("glitch_e1/d4", out4, 1'b0);
    applyStimulus(0, 0);
    checkOutput("glitch_e2/d4", out4, 1'b1);
    applyStimulus(0, 0);
    checkOutput("glitch_e3/d4", out4, 1'b1);
    applyStimulus(0, 0);
    checkOutput("glitch_e4/d4", out4, 1'b0);

    // Reset value 1 held for DEPTH-1 cycles after release.
    $display("[TB] post-reset fill with RESET_VAL=1");
    applyStimulus(1, 0);
    checkOutput("rv_reset/d8", out8, 1'b1);
    checkOutput("rv_reset/d1", out1, 1'b1);
    for (int k = 1; k <= 8; k++) begin
      applyStimulus(0, 0);
      checkOutput($sformatf("rv_fill%0d/d8", k), out8, (k < 8) ? 1'b1 : 1'b0);
      checkOutput($sformatf("rv_fill%0d/d1", k), out1, 1'b0);
    end

    // Random stream with occasional resets against the reference.
    $display("[TB] random phase");
    for (int k = 0; k < 400; k++) begin
      applyStimulus($urandom_range(0, 19) == 0, $urandom_range(0, 1) == 1);
      checkAllModel($sformatf("rand%0d", k));
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_count, miss_count);
    $finish;
  end

endmodule
